// File: rtl/target_judge_if.sv
// rtl/target_judge_if.sv - game-side bus of target_judge: control inputs, buttons, lit target, hit/miss/score.
interface target_judge_if #(
    parameter int N_TARGETS = 4
);
    logic                 enable;
    logic                 clear;
    logic                 game_over;
    logic [N_TARGETS-1:0] btn;
    logic [N_TARGETS-1:0] target;
    logic                 hit;
    logic                 miss;
    logic [7:0]           score;
    logic                 busy;

    modport master (
        output enable, clear, game_over, btn,
        input  target, hit, miss, score, busy
    );

    modport slave (
        input  enable, clear, game_over, btn,
        output target, hit, miss, score, busy
    );
endinterface

// File: rtl/target_judge.sv
// rtl/target_judge.sv - whack-a-target judge: lights an LFSR-chosen target, times the press, pulses hit/miss.
// Optional TARGET_NO_REPEAT_EN: the same target is never lit in two consecutive rounds.
module target_judge #(
    parameter int N_TARGETS  = 4,
    parameter int GAP_CYC    = 50_000_000,
    parameter int WINDOW_CYC = 100_000_000
) (
    input  logic          clk,
    input  logic          rst,
    target_judge_if.slave bus
);
    localparam int IDX_W = $clog2(N_TARGETS);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int WIN_W = $clog2(WINDOW_CYC);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GAP,
        S_ARMED,
        S_RESULT
    } state_t;

    state_t               state;
    logic [15:0]          lfsr;
    logic [N_TARGETS-1:0] btn_d;
    logic [GAP_W-1:0]     gap_cnt;
    logic [WIN_W-1:0]     win_cnt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     next_idx;
    logic [N_TARGETS-1:0] target_q;
    logic                 hit_q;
    logic                 miss_q;
    logic [7:0]           score_q;
    logic                 busy_q;
`ifdef TARGET_NO_REPEAT_EN
    logic [IDX_W-1:0]     prev_idx;
`endif

    logic [N_TARGETS-1:0] btn_edge;
    logic                 wrong_press;
    logic                 right_press;
    logic                 halt;

    function automatic logic [N_TARGETS-1:0] one_hot(input logic [IDX_W-1:0] i);
        one_hot    = '0;
        one_hot[i] = 1'b1;
    endfunction

    // target_q is one-hot of idx throughout ARMED, so it doubles as the press mask
    assign btn_edge    = bus.btn & ~btn_d;
    assign wrong_press = |(btn_edge & ~target_q);
    assign right_press = |(btn_edge & target_q);
    assign halt        = !bus.enable || bus.game_over;

    always_comb begin
        next_idx = lfsr[IDX_W-1:0];
`ifdef TARGET_NO_REPEAT_EN
        if (next_idx == prev_idx) begin
            next_idx = prev_idx + IDX_W'(1);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            lfsr     <= 16'hACE1;
            btn_d    <= '1;
            gap_cnt  <= '0;
            win_cnt  <= '0;
            idx      <= '0;
            target_q <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            score_q  <= 8'd0;
            busy_q   <= 1'b0;
`ifdef TARGET_NO_REPEAT_EN
            prev_idx <= '0;
`endif
        end else begin
            // Galois form of x^16+x^14+x^13+x^11+1, free-running in every state
            lfsr   <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            btn_d  <= bus.btn;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;

            if (bus.clear) begin
                state    <= S_IDLE;
                target_q <= '0;
                score_q  <= 8'd0;
                busy_q   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (!halt) begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                            busy_q  <= 1'b1;
                        end
                    end

                    S_GAP: begin
                        if (halt) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end else if (gap_cnt == GAP_LAST) begin
                            state    <= S_ARMED;
                            idx      <= next_idx;
                            target_q <= one_hot(next_idx);
                            win_cnt  <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end

                    S_ARMED: begin
                        if (halt) begin
                            state    <= S_IDLE;
                            target_q <= '0;
                            busy_q   <= 1'b0;
                        end else if (wrong_press) begin
                            state    <= S_RESULT;
                            target_q <= '0;
                            miss_q   <= 1'b1;
                        end else if (right_press) begin
                            state    <= S_RESULT;
                            target_q <= '0;
                            hit_q    <= 1'b1;
                            score_q  <= (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        end else if (win_cnt == WIN_LAST) begin
                            state    <= S_RESULT;
                            target_q <= '0;
                            miss_q   <= 1'b1;
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                        end
                    end

                    S_RESULT: begin
`ifdef TARGET_NO_REPEAT_EN
                        prev_idx <= idx;
`endif
                        gap_cnt <= '0;
                        if (halt) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            state <= S_GAP;
                        end
                    end

                    default: begin
                        state    <= S_IDLE;
                        target_q <= '0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.target = target_q;
    assign bus.hit    = hit_q;
    assign bus.miss   = miss_q;
    assign bus.score  = score_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_target_judge.sv
// tb/tb_target_judge.sv - self-checking bench for target_judge (N_TARGETS=4, GAP_CYC=4, WINDOW_CYC=8).
// Honours TARGET_NO_REPEAT_EN in the reference model and adds the no-repeat check when defined.
module tb_target_judge;
    localparam int N   = 4;
    localparam int GAP = 4;
    localparam int WIN = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0;
    logic         clear = 1'b0;
    logic         game_over = 1'b0;
    logic [N-1:0] btn = '0;

    target_judge_if #(.N_TARGETS(N)) bus ();
    assign bus.enable    = enable;
    assign bus.clear     = clear;
    assign bus.game_over = game_over;
    assign bus.btn       = btn;

    target_judge #(
        .N_TARGETS (N),
        .GAP_CYC   (GAP),
        .WINDOW_CYC(WIN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a round is "run" with m_t cycles elapsed; the result cycle is m_res.
    logic [15:0]  m_lfsr;
    logic [N-1:0] m_btn_prev;
    int           m_score, m_t, m_idx, m_prev, m_kind;
    bit           m_run, m_res;
    bit           last_pulse;

    typedef struct {
        int           want;
        int           kind;     // 0 lit bit, 1 fixed pattern, 2 no press, 3 neighbour of lit bit
        logic [N-1:0] fixed;
        int           delay;
        bit           exp_hit;
        bit           exp_miss;
        int           dscore;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_lfsr     = 16'hACE1;
        m_btn_prev = '1;
        m_score    = 0;
        m_t        = 0;
        m_idx      = 0;
        m_prev     = 0;
        m_kind     = 0;
        m_run      = 1'b0;
        m_res      = 1'b0;
        last_pulse = 1'b0;
    endtask

    function automatic int pick_idx();
        int p;
        p = int'(m_lfsr) % N;
`ifdef TARGET_NO_REPEAT_EN
        if (p == m_prev) p = (p + 1) % N;
`endif
        return p;
    endfunction

    task automatic finish_round(input int k);
        m_run  = 1'b0;
        m_res  = 1'b1;
        m_kind = k;
        if (k == 1 && m_score < 255) m_score++;
    endtask

    task automatic model_step();
        logic [N-1:0] edges, mask;
        bit halt;
        if (!rst) begin
            model_reset();
            return;
        end
        edges      = btn & ~m_btn_prev;
        m_btn_prev = btn;
        halt       = !enable || game_over;
        mask       = N'(1) << m_idx;
        if (clear) begin
            m_run = 1'b0;
            m_res = 1'b0;
            m_score = 0;
        end else if (m_res) begin
            m_res  = 1'b0;
            m_prev = m_idx;
            m_run  = !halt;
            m_t    = 0;
        end else if (!m_run) begin
            if (!halt) begin
                m_run = 1'b1;
                m_t   = 0;
            end
        end else if (halt) begin
            m_run = 1'b0;
        end else if (m_t < GAP) begin
            if (m_t == GAP - 1) m_idx = pick_idx();
            m_t++;
        end else begin
            if ((edges & ~mask) != 0)      finish_round(2);
            else if ((edges & mask) != 0)  finish_round(1);
            else if (m_t - GAP == WIN - 1) finish_round(2);
            else m_t++;
        end
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    endtask

    task automatic check_model();
        logic [N-1:0] et;
        bit eh, em, eb;
        et = (m_run && !m_res && m_t >= GAP) ? (N'(1) << m_idx) : '0;
        eh = m_res && (m_kind == 1);
        em = m_res && (m_kind == 2);
        eb = m_run || m_res;
        checks++;
        if (bus.target !== et || bus.hit !== eh || bus.miss !== em || bus.score !== 8'(m_score) ||
            bus.busy !== eb || (bus.hit && bus.miss) || (last_pulse && (bus.hit || bus.miss))) begin
            errors++;
            $display("FAIL model @%0t: target=%b want %b hit=%b want %b miss=%b want %b score=%0d want %0d busy=%b want %b",
                     $time, bus.target, et, bus.hit, eh, bus.miss, em, bus.score, m_score, bus.busy, eb);
        end
        last_pulse = bus.hit || bus.miss;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic wait_armed(input int want);
        int n;
        n = 0;
        btn = '0;
        while (!(m_run && !m_res && m_t == GAP && (want < 0 || m_idx == want))) begin
            tick();
            n++;
            if (n > 600) begin
                checks++;
                errors++;
                $display("FAIL wait_armed: no armed round with index %0d within budget", want);
                return;
            end
        end
    endtask

    task automatic play(input int want, input int kind, input logic [N-1:0] fixed, input int delay);
        logic [N-1:0] mask;
        wait_armed(want);
        mask = N'(1) << m_idx;
        repeat (delay) tick();
        case (kind)
            0:       btn = mask;
            1:       btn = fixed;
            3:       btn = {mask[N-2:0], mask[N-1]};
            default: btn = '0;
        endcase
        tick();
        btn = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        logic [N-1:0] first_lit, prev_lit;

        vecs[0] = '{-1, 0, 4'b0000, 3, 1'b1, 1'b0, 1};
        vecs[1] = '{ 2, 1, 4'b0101, 0, 1'b0, 1'b1, 0};
        vecs[2] = '{ 1, 1, 4'b0011, 1, 1'b0, 1'b1, 0};
        vecs[3] = '{-1, 0, 4'b0000, 7, 1'b1, 1'b0, 1};
        vecs[4] = '{-1, 2, 4'b0000, 7, 1'b0, 1'b1, 0};
        vecs[5] = '{-1, 3, 4'b0000, 0, 1'b0, 1'b1, 0};
        vecs[6] = '{-1, 0, 4'b0000, 0, 1'b1, 1'b0, 1};

        model_reset();
        #1;
        check_model();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("idle_busy", bus.busy, 0);

        // Full timeout round with no buttons
        enable = 1'b1;
        first_lit = '0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c <= 4) begin
                chk("gap_dark", bus.target, 0);
            end else if (c <= 12) begin
                if (c == 5) first_lit = bus.target;
                chk("armed_onehot", $onehot(bus.target), 1);
                chk("armed_steady", bus.target, first_lit);
            end else if (c == 13) begin
                chk("timeout_miss", bus.miss, 1);
                chk("timeout_nohit", bus.hit, 0);
                chk("timeout_score", bus.score, 0);
                chk("timeout_dark", bus.target, 0);
            end else begin
                chk("next_gap_dark", bus.target, 0);
                chk("miss_one_cycle", bus.miss, 0);
                chk("next_gap_busy", bus.busy, 1);
            end
        end

        for (int v = 0; v < 7; v++) begin
            sc = m_score;
            play(vecs[v].want, vecs[v].kind, vecs[v].fixed, vecs[v].delay);
            chk($sformatf("vec%0d_hit", v), bus.hit, 32'(vecs[v].exp_hit));
            chk($sformatf("vec%0d_miss", v), bus.miss, 32'(vecs[v].exp_miss));
            chk($sformatf("vec%0d_score", v), bus.score, sc + vecs[v].dscore);
            chk($sformatf("vec%0d_dark", v), bus.target, 0);
        end

        // Saturation over 300 correct presses
        prev_lit = '0;
        for (int r = 0; r < 300; r++) begin
            wait_armed(-1);
`ifdef TARGET_NO_REPEAT_EN
            if (r > 0) chk("no_repeat", (bus.target != prev_lit), 1);
`endif
            prev_lit = bus.target;
            play(-1, 0, '0, $urandom_range(0, 7));
            chk("sat_hit", bus.hit, 1);
        end
        chk("sat_score", bus.score, 255);

        // clear from a result cycle and from mid-ARMED
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_score", bus.score, 0);
        chk("clear_busy", bus.busy, 0);
        for (int r = 0; r < 7; r++) play(-1, 0, '0, 2);
        chk("score_seven", bus.score, 7);
        wait_armed(-1);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear7_score", bus.score, 0);
        chk("clear7_busy", bus.busy, 0);
        chk("clear7_dark", bus.target, 0);
        chk("clear7_nopulse", bus.hit | bus.miss, 0);

        // game_over mid-ARMED
        for (int r = 0; r < 3; r++) play(-1, 0, '0, 1);
        wait_armed(-1);
        repeat (3) tick();
        game_over = 1'b1;
        tick();
        chk("go_dark", bus.target, 0);
        chk("go_nopulse", bus.hit | bus.miss, 0);
        chk("go_busy", bus.busy, 0);
        chk("go_score", bus.score, 3);
        repeat (3) tick();
        chk("go_held_idle", bus.busy, 0);
        game_over = 1'b0;

        // Asynchronous reset mid-GAP
        for (int r = 0; r < 2; r++) play(-1, 0, '0, 0);
        tick();
        tick();
        chk("pre_rst_busy", bus.busy, 1);
        chk("pre_rst_score", bus.score, 5);
        rst = 1'b0;
        #1;
        chk("arst_target", bus.target, 0);
        chk("arst_hit", bus.hit, 0);
        chk("arst_miss", bus.miss, 0);
        chk("arst_score", bus.score, 0);
        chk("arst_busy", bus.busy, 0);
        model_reset();
        tick();
        rst = 1'b1;

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                if (m_run && !m_res && m_t >= GAP && $urandom_range(0, 1) == 1) btn = N'(1) << m_idx;
                else btn = N'($urandom);
            end
            enable    = ($urandom_range(0, 199) != 0);
            game_over = ($urandom_range(0, 299) == 0);
            clear     = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/target_judge.md
Name: target_judge

Overview:
- Upstream stage of the `lives` counter in the whack-a-target game.
- Picks a pseudo-random target, lights it, and times the player's button response.
- Emits a one-cycle `miss` pulse that drives the `lives` miss input, and a `hit` pulse that drives the score.
- Halts while `game_over` from `lives` is high.

Parameters:
N_TARGETS, 4, number of targets/buttons; power of two, 2..16
GAP_CYC, 50_000_000, dark cycles between targets
WINDOW_CYC, 100_000_000, cycles a target stays lit; must be at least 2
IDX_W, $clog2(N_TARGETS), target index width (derived; do not override)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
enable  input  1  game running (level)
clear  input  1  synchronous: zero score, return to IDLE
game_over  input  1  from `lives`; halts the block
btn  input  N_TARGETS  debounced, synchronised buttons (level, active-high)
target  output  N_TARGETS  one-hot lit target; 0 when none lit
hit  output  1  one-cycle pulse on a correct press
miss  output  1  one-cycle pulse on timeout or wrong press
score  output  8  hit count, saturating
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, target=0, hit=0, miss=0, score=0, busy=0, btn_d=all-ones, lfsr=16'hACE1, prev_idx=0.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances every cycle regardless of state. Never all-zero.
- Edge detect: btn_d <= btn every cycle. edge = btn & ~btn_d.
  - btn_d resetting to all-ones means buttons held through reset produce no edge.
  - Edges outside ARMED are discarded. A button held from GAP into ARMED produces no edge.
- FSM states: IDLE, GAP, ARMED, RESULT.
  - IDLE: target=0. If enable && !game_over && !clear, go to GAP with gap counter=0.
  - GAP: target=0. Counts GAP_CYC cycles. On the last cycle, latch idx=lfsr[IDX_W-1:0] and go to ARMED with window counter=0.
  - ARMED: target = one-hot(idx).
    - Any edge on a non-target bit: result=MISS (wrong press takes priority, even if the correct bit also has an edge in the same cycle).
    - Else an edge on the target bit: result=HIT.
    - Else window counter == WINDOW_CYC-1: result=MISS (timeout).
    - Else increment the window counter.
    - On any result, go to RESULT. An edge on the final window cycle counts as a press, not a timeout.
  - RESULT: target=0. hit or miss =1 for exactly this cycle. On HIT, score = min(score+1, 255). prev_idx <= idx. Next state is GAP if enable && !game_over, else IDLE.
- Latency: the pulse is asserted the cycle after the ARMED cycle in which the edge or timeout is seen. A full timeout round is GAP_CYC + WINDOW_CYC + 1 cycles.
- Abort: enable=0 or game_over=1 in GAP or ARMED forces IDLE next cycle. No pulse, score held.
- clear=1: from any state, IDLE next cycle, score=0, no pulse. clear has priority over all other inputs.
- hit and miss are never high together. They are never high for two consecutive cycles.

Optional Feature:
- Macro: TARGET_NO_REPEAT_EN.
- Defined: on the GAP->ARMED transition, if lfsr[IDX_W-1:0]==prev_idx, then idx = (prev_idx+1) mod N_TARGETS. The same target is never lit twice in a row.
- Undefined: idx = lfsr[IDX_W-1:0] unconditionally; repeats allowed. prev_idx logic is omitted.

Test Plan (N_TARGETS=4, GAP_CYC=4, WINDOW_CYC=8):
- Reset, enable=1, no buttons -> target=0 for 4 cycles, then one-hot for 8 cycles. Then miss=1 for one cycle, score=0, and target returns to 0 for the next GAP.
- Raise btn bit equal to the lit index 3 cycles into ARMED -> hit=1 the following cycle, score 0->1, target=0.
- Lit target 2; raise btn=4'b0101 -> miss=1, hit=0, score unchanged.
- Lit target 1; raise btn=4'b0011 in the same cycle -> miss=1 (wrong press wins).
- Drive 300 correct hits -> score saturates at 255, with no wrap to 0.
- game_over=1 mid-ARMED -> IDLE next cycle, target=0, no pulse. clear=1 at score 7 -> score=0, IDLE. rst=0 mid-GAP -> all outputs 0 immediately, without waiting for a clock edge.
- With TARGET_NO_REPEAT_EN, 200 rounds -> no two consecutive ARMED phases show the same target.
